prbs_word_gen: RTL and testbench
================================

Name: prbs_word_gen

Overview:
Parametrised successor to the fixed 239-bit LFSR bit generator. Emits K-bit pseudo-random message words from an L-bit Galois LFSR to feed the product-code encoder and the BER test path. Adds seed-load control, deterministic test patterns, a frame-counted run, a valid/ready output handshake with stall, and STEPS LFSR advances per word.

Parameters:
L, 256, LFSR length in bits.
K, 239, output word width; K <= L.
TAPS, L-bit mask with bits {255,254,252,249,244} set, feedback XOR mask.
STEPS, 1, LFSR advances per emitted word (1..8), unrolled combinationally.
FW, 16, width of the frame counter.
DEFAULT_SEED, L'h1, LFSR value after reset and substitute for an all-zero seed.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
seed_load  in  1  load seed into the LFSR; honoured in IDLE only
seed  in  L  seed value
mode  in  2  00 PRBS, 01 all-zero, 10 all-one, 11 alternating (bit i = i[0]); sampled at start
start  in  1  begin a run; honoured in IDLE only
abort  in  1  synchronous return to IDLE
num_frames  in  FW  words per run; 0 = continuous; sampled at start
out_ready  in  1  consumer accepts bits
out_valid  out  1  bits holds a valid word
bits  out  K  message word
frame_idx  out  FW  0-based index of the word on bits
busy  out  1  high in RUN
done  out  1  one-cycle pulse when a run completes
seed_err  out  1  one-cycle pulse when an all-zero seed is loaded

Behaviour:
- Reset (reset=0, async): lfsr=DEFAULT_SEED, state=IDLE, out_valid=0, bits=0, frame_idx=0, busy=0, done=0, seed_err=0.
- LFSR step: fb=lfsr[0]; next=(lfsr>>1) ^ ({L{fb}} & TAPS). A word step applies this STEPS times.
- PRBS word = lfsr[K-1:0] after the word step.
- Other modes: output is the fixed pattern for the selected mode, and the LFSR still steps each word so PRBS resumes in phase.
- States:
  - IDLE -> RUN on start (not abort).
  - RUN -> DONE after the last word is accepted.
  - DONE -> IDLE unconditionally after one cycle, with done=1 during that cycle.
- Word load: in RUN, while words remain and (!out_valid || out_ready):
  - lfsr<=step(lfsr), bits<=word, out_valid<=1.
  - frame_idx<=0 on the first load, otherwise frame_idx+1.
- Start-cycle load: the first word is loaded in the same edge that samples start, so out_valid rises 1 cycle after start.
- Throughput: one word per cycle when out_ready stays high.
- Stall: with out_valid=1 and out_ready=0, bits, frame_idx and lfsr hold unchanged.
- Run completion: the run ends when the handshake occurs on frame_idx==num_frames-1 (num_frames!=0).
  - That cycle: out_valid<=0 and state<=DONE.
  - num_frames=0 never completes, and frame_idx wraps modulo 2^FW.
- seed_load in IDLE: lfsr<=seed, or DEFAULT_SEED with seed_err=1 if seed==0. Ignored outside IDLE.
- Simultaneous seed_load and start in IDLE: the seed loads first, and the first word is step(seed).
- abort: takes priority over everything except reset.
  - Forces IDLE and out_valid=0; done is not pulsed.
  - lfsr keeps its current value, so a later start continues the sequence.
- Reset mid-run: all state returns to reset values immediately; any pending word is lost.
- busy=1 exactly when state==RUN.

Decomposition:
- Package prbs_pkg holds:
  - mode encodings MODE_PRBS/ZERO/ONE/ALT;
  - state encodings IDLE/RUN/DONE;
  - default TAPS mask for L=256;
  - function lfsr_step(lfsr,taps).
- Sub-module lfsr_stepper (combinational, parameters L/TAPS/STEPS) computes the STEPS-fold advance.
- Top level holds the FSM, frame counter and output register.

Test Plan:
- Step chain: reset; seed_load seed=2; start, mode=00, num_frames=3, out_ready=1.
  - Words are 0x1, 0x0, 0x0 on consecutive cycles, with frame_idx 0,1,2.
  - out_valid drops after the third word; done pulses 1 cycle later.
  - busy is high from 1 cycle after start through the last word.
- Backpressure: seed=2, num_frames=2, out_ready=0 for 5 cycles after out_valid.
  - bits=0x1 and frame_idx=0 are held stable for all 5 cycles.
  - After out_ready rises, the second word 0x0 appears next cycle.
- Zero seed: seed_load seed=0 -> seed_err pulses once, and a subsequent run matches the DEFAULT_SEED reference model.
- Modes and STEPS:
  - mode=10 -> bits all ones; mode=11 -> bits[0]=0, bits[1]=1.
  - STEPS=2 build with seed=4 -> first word 0x1.
- Abort and continuation: abort mid continuous run (num_frames=0) at frame 7.
  - Next cycle: out_valid=0, IDLE, no done pulse.
  - Restart continues the LFSR sequence from word 8 of the model.
- Async reset mid-stall: assert reset=0 mid-stall -> out_valid, bits and frame_idx are 0 before the next clk edge.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared types, default tap mask and the single-step LFSR rule for the PRBS
// word generator.
package prbs_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS = 2'b00,
    MODE_ZERO = 2'b01,
    MODE_ONE  = 2'b10,
    MODE_ALT  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest LFSR the step helper handles; narrower registers are zero-extended.
  localparam int unsigned LFSR_MAX = 1024;

  localparam logic [255:0] TAPS_256 = (256'd1 << 255) | (256'd1 << 254) |
                                      (256'd1 << 252) | (256'd1 << 249) |
                                      (256'd1 << 244);

  function automatic logic [LFSR_MAX-1:0] lfsr_step(
    input logic [LFSR_MAX-1:0] lfsr,
    input logic [LFSR_MAX-1:0] taps
  );
    return (lfsr >> 1) ^ ({LFSR_MAX{lfsr[0]}} & taps);
  endfunction

endpackage

// File: rtl/lfsr_stepper.sv
// Combinational STEPS-fold advance of an L-bit Galois LFSR.
module lfsr_stepper
  import prbs_pkg::*;
#(
  parameter int unsigned   L     = 256,
  parameter logic [L-1:0]  TAPS  = L'(TAPS_256),
  parameter int unsigned   STEPS = 1
) (
  input  logic [L-1:0] lfsr_in,
  output logic [L-1:0] lfsr_out
);

  logic [L-1:0] acc;

  always_comb begin
    acc = lfsr_in;
    for (int unsigned i = 0; i < STEPS; i++) begin
      acc = L'(lfsr_step(LFSR_MAX'(acc), LFSR_MAX'(TAPS)));
    end
    lfsr_out = acc;
  end

endmodule

// File: rtl/prbs_word_gen.sv
// K-bit pseudo-random / test-pattern word source with seed load, frame-counted
// runs and a valid/ready output register.
module prbs_word_gen
  import prbs_pkg::*;
#(
  parameter int unsigned  L            = 256,
  parameter int unsigned  K            = 239,
  parameter logic [L-1:0] TAPS         = L'(TAPS_256),
  parameter int unsigned  STEPS        = 1,
  parameter int unsigned  FW           = 16,
  parameter logic [L-1:0] DEFAULT_SEED = L'(1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seed_load,
  input  logic [L-1:0]  seed,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] num_frames,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [K-1:0]  bits,
  output logic [FW-1:0] frame_idx,
  output logic          busy,
  output logic          done,
  output logic          seed_err
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d, word_mode;
  logic [FW-1:0] num_frames_q, num_frames_d;
  logic [FW-1:0] frame_idx_q, frame_idx_d;
  logic [L-1:0]  lfsr_q, lfsr_d;
  logic [L-1:0]  loaded_seed, step_in, step_out;
  logic [K-1:0]  bits_q, bits_d;
  logic [K-1:0]  alt_word, word;
  logic          out_valid_q, out_valid_d;
  logic          seed_err_q, seed_err_d;
  logic          handshake, last_word;

  lfsr_stepper #(
    .L    (L),
    .TAPS (TAPS),
    .STEPS(STEPS)
  ) u_stepper (
    .lfsr_in (step_in),
    .lfsr_out(step_out)
  );

  always_comb begin
    alt_word = '0;
    for (int unsigned i = 0; i < K; i++) begin
      alt_word[i] = i[0];
    end
  end

  always_comb begin
    loaded_seed = (seed == '0) ? DEFAULT_SEED : seed;
    // A seed loaded together with start is stepped in the same cycle.
    step_in     = (state_q == IDLE && seed_load) ? loaded_seed : lfsr_q;
    word_mode   = (state_q == IDLE) ? mode_e'(mode) : mode_q;

    case (word_mode)
      MODE_ZERO: word = '0;
      MODE_ONE:  word = '1;
      MODE_ALT:  word = alt_word;
      default:   word = step_out[K-1:0];
    endcase

    handshake = out_valid_q && out_ready;
    last_word = handshake && (num_frames_q != '0) &&
                (frame_idx_q == num_frames_q - FW'(1));

    state_d      = state_q;
    mode_d       = mode_q;
    num_frames_d = num_frames_q;
    frame_idx_d  = frame_idx_q;
    lfsr_d       = lfsr_q;
    bits_d       = bits_q;
    out_valid_d  = out_valid_q;
    seed_err_d   = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (seed_load) begin
            lfsr_d     = loaded_seed;
            seed_err_d = (seed == '0);
          end
          if (start) begin
            state_d      = RUN;
            mode_d       = mode_e'(mode);
            num_frames_d = num_frames;
            lfsr_d       = step_out;
            bits_d       = word;
            out_valid_d  = 1'b1;
            frame_idx_d  = '0;
          end
        end
        RUN: begin
          if (last_word) begin
            out_valid_d = 1'b0;
            state_d     = DONE;
          end else if (!out_valid_q || out_ready) begin
            lfsr_d      = step_out;
            bits_d      = word;
            out_valid_d = 1'b1;
            frame_idx_d = out_valid_q ? frame_idx_q + FW'(1) : '0;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= MODE_PRBS;
      num_frames_q <= '0;
      frame_idx_q  <= '0;
      lfsr_q       <= DEFAULT_SEED;
      bits_q       <= '0;
      out_valid_q  <= 1'b0;
      seed_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      num_frames_q <= num_frames_d;
      frame_idx_q  <= frame_idx_d;
      lfsr_q       <= lfsr_d;
      bits_q       <= bits_d;
      out_valid_q  <= out_valid_d;
      seed_err_q   <= seed_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bits      = bits_q;
  assign frame_idx = frame_idx_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign seed_err  = seed_err_q;

endmodule

// File: tb/tb_prbs_word_gen.sv
// Scoreboarded bench for prbs_word_gen: STEPS=1 and STEPS=2 instances share stimulus.
module tb_prbs_word_gen;

  localparam int unsigned L  = 256;
  localparam int unsigned K  = 239;
  localparam int unsigned FW = 16;
  localparam logic [L-1:0] TB_TAPS = (256'd1 << 255) | (256'd1 << 254) |
                                     (256'd1 << 252) | (256'd1 << 249) |
                                     (256'd1 << 244);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          seed_load = 1'b0;
  logic [L-1:0]  seed = '0;
  logic [1:0]    mode = 2'b00;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [FW-1:0] num_frames = '0;
  logic          out_ready = 1'b0;

  logic          out_valid, busy, done, seed_err;
  logic [K-1:0]  bits;
  logic [FW-1:0] frame_idx;
  logic          out_valid2, busy2, done2, seed_err2;
  logic [K-1:0]  bits2;
  logic [FW-1:0] frame_idx2;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [K-1:0]  w;
    logic [FW-1:0] idx;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  logic [L-1:0] m1 = L'(1);
  logic [L-1:0] m2 = L'(1);

  prbs_word_gen #(.L(L), .K(K), .STEPS(1), .FW(FW)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .mode(mode),
    .start(start), .abort(abort), .num_frames(num_frames), .out_ready(out_ready),
    .out_valid(out_valid), .bits(bits), .frame_idx(frame_idx), .busy(busy),
    .done(done), .seed_err(seed_err)
  );

  prbs_word_gen #(.L(L), .K(K), .STEPS(2), .FW(FW)) dut2 (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed), .mode(mode),
    .start(start), .abort(abort), .num_frames(num_frames), .out_ready(out_ready),
    .out_valid(out_valid2), .bits(bits2), .frame_idx(frame_idx2), .busy(busy2),
    .done(done2), .seed_err(seed_err2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [L-1:0] adv(input logic [L-1:0] v, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) v = (v >> 1) ^ (v[0] ? TB_TAPS : '0);
    return v;
  endfunction

  function automatic logic [K-1:0] pattern(input logic [1:0] md, input logic [L-1:0] v);
    logic [K-1:0] p;
    case (md)
      2'b01:   p = '0;
      2'b10:   p = '1;
      2'b11:   for (int unsigned i = 0; i < K; i++) p[i] = (i % 2 == 1);
      default: p = v[K-1:0];
    endcase
    return p;
  endfunction

  task automatic chk(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [1:0] md, input int count);
    for (int j = 0; j < count; j++) begin
      m1 = adv(m1, 1);
      m2 = adv(m2, 2);
      q1.push_back('{w: pattern(md, m1), idx: FW'(j)});
      q2.push_back('{w: pattern(md, m2), idx: FW'(j)});
    end
  endtask

  // Drives a start (optionally with seed) and queues the words it will produce.
  task automatic issue(input logic ld, input logic [L-1:0] sd, input logic [1:0] md,
                       input int n, input int pushes);
    seed_load  = ld;
    seed       = sd;
    mode       = md;
    num_frames = FW'(n);
    start      = 1'b1;
    if (ld) begin
      m1 = (sd == '0) ? L'(1) : sd;
      m2 = m1;
    end
    push(md, pushes);
  endtask

  task automatic release_start();
    @(posedge clk); #1;
    start     = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic finish_run(input string name, input bit rand_ready);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
    end
    chk({name, "_done_seen"}, L'(seen), L'(1));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && out_valid && out_ready) begin
      if (q1.size() == 0) begin
        n_total++;
        $display("FAIL dut1_unexpected: got word idx %0d expected none", frame_idx);
      end else begin
        e = q1.pop_front();
        chk("dut1_word", L'(bits), L'(e.w));
        chk("dut1_idx", L'(frame_idx), L'(e.idx));
      end
    end
    if (reset && out_valid2 && out_ready) begin
      if (q2.size() == 0) begin
        n_total++;
        $display("FAIL dut2_unexpected: got word idx %0d expected none", frame_idx2);
      end else begin
        e = q2.pop_front();
        chk("dut2_word", L'(bits2), L'(e.w));
        chk("dut2_idx", L'(frame_idx2), L'(e.idx));
      end
    end
  end

  initial begin
    logic [L-1:0] sd;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", L'(out_valid), L'(0));
    chk("rst_bits", L'(bits), L'(0));
    chk("rst_idx", L'(frame_idx), L'(0));
    chk("rst_busy", L'(busy), L'(0));
    chk("rst_done", L'(done), L'(0));
    chk("rst_seed_err", L'(seed_err), L'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // step chain: seed 2 loaded with start, three words back to back
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(1'b1, L'(2), 2'b00, 3, 3);
    @(negedge clk);
    chk("chain_busy_pre", L'(busy), L'(0));
    release_start();
    @(negedge clk);
    chk("chain_w0", L'(bits), L'(1));
    chk("chain_v0", L'(out_valid), L'(1));
    chk("chain_busy0", L'(busy), L'(1));
    @(negedge clk);
    chk("chain_idx1", L'(frame_idx), L'(1));
    chk("chain_busy1", L'(busy), L'(1));
    @(negedge clk);
    chk("chain_idx2", L'(frame_idx), L'(2));
    chk("chain_busy2", L'(busy), L'(1));
    @(negedge clk);
    chk("chain_v_drop", L'(out_valid), L'(0));
    chk("chain_done", L'(done), L'(1));
    chk("chain_busy_end", L'(busy), L'(0));
    @(negedge clk);
    chk("chain_done_low", L'(done), L'(0));

    // backpressure: first word held for 5 stalled cycles
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(1'b1, L'(2), 2'b00, 2, 2);
    release_start();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_bits", L'(bits), L'(1));
      chk("bp_hold_idx", L'(frame_idx), L'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_w1", L'(bits), L'(0));
    chk("bp_idx1", L'(frame_idx), L'(1));
    finish_run("bp", 1'b0);

    // zero seed falls back to the default seed
    @(posedge clk); #1;
    seed_load = 1'b1;
    seed      = '0;
    m1 = L'(1);
    m2 = L'(1);
    @(posedge clk); #1;
    seed_load = 1'b0;
    @(negedge clk);
    chk("zero_seed_err", L'(seed_err), L'(1));
    @(negedge clk);
    chk("zero_seed_err_low", L'(seed_err), L'(0));
    @(posedge clk); #1;
    issue(1'b0, '0, 2'b00, 5, 5);
    release_start();
    finish_run("zero_run", 1'b1);

    // fixed patterns still advance the LFSR
    for (int md = 2; md < 4; md++) begin
      @(posedge clk); #1;
      issue(1'b0, '0, 2'(md), 3, 3);
      release_start();
      finish_run("mode_run", 1'b1);
    end

    // seed 4: one step gives 2, two steps give 1
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(1'b1, L'(4), 2'b00, 2, 2);
    release_start();
    @(negedge clk);
    chk("steps2_w0", L'(bits2), L'(1));
    chk("steps1_w0", L'(bits), L'(2));
    finish_run("steps_run", 1'b0);

    // abort a continuous run while frame 7 is stalled
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) sd[i*32 +: 32] = $urandom();
    sd[0] = 1'b1;
    issue(1'b1, sd, 2'b00, 0, 8);
    void'(q1.pop_back());
    void'(q2.pop_back());
    release_start();
    repeat (7) @(posedge clk);
    #1;
    out_ready = 1'b0;
    abort     = 1'b1;
    @(negedge clk);
    chk("abort_idx7", L'(frame_idx), L'(7));
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", L'(out_valid), L'(0));
    chk("abort_busy", L'(busy), L'(0));
    chk("abort_no_done", L'(done), L'(0));
    @(negedge clk);
    chk("abort_no_done2", L'(done), L'(0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(1'b0, '0, 2'b00, 4, 4);
    release_start();
    finish_run("resume_run", 1'b1);

    // randomized runs
    for (int it = 0; it < 8; it++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) sd[i*32 +: 32] = $urandom();
      if ($urandom_range(0, 3) == 0) sd = '0;
      begin
        int n = $urandom_range(1, 6);
        issue(1'($urandom_range(0, 1)), sd, 2'($urandom_range(0, 3)), n, n);
      end
      release_start();
      finish_run("rand_run", 1'b1);
    end

    // async reset while stalled
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(1'b0, '0, 2'b00, 3, 3);
    release_start();
    @(posedge clk); #3;
    reset = 1'b0;
    q1.delete();
    q2.delete();
    m1 = L'(1);
    m2 = L'(1);
    #1;
    chk("arst_valid", L'(out_valid), L'(0));
    chk("arst_bits", L'(bits), L'(0));
    chk("arst_idx", L'(frame_idx), L'(0));
    chk("arst_busy", L'(busy), L'(0));
    chk("arst_valid2", L'(out_valid2), L'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(1'b0, '0, 2'b00, 2, 2);
    release_start();
    finish_run("post_reset_run", 1'b0);

    @(negedge clk);
    chk("q1_drained", L'(q1.size()), L'(0));
    chk("q2_drained", L'(q2.size()), L'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
